// File: rtl/lsu_pkg.sv
// Shared types, Funct3 encodings and lane helpers for the load/store unit.
package lsu_pkg;

  // Funct3 access encodings (011/110/111 fall through to word)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned CNT_W = 8;

  // Byte-enable patterns before lane shifting
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Access size from Funct3
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  // Zero-extending load variants
  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'(BE_B << off);
      SZ_H:    return 4'(BE_H << {off[1], 1'b0});
      default: return BE_W;
    endcase
  endfunction

  // Replicate the right-aligned byte/half across all lanes
  function automatic logic [31:0] lane_wdata(input lsu_size_t sz, input logic [31:0] d);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select plus sign/zero extension (combinational).
//   rdata_i    : raw 32-bit memory word
//   offset_i   : byte offset within the word
//   size_i     : access size
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : extended result
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  lsu_size_t   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] lane_c;

  // Aligned halves/words always have zero low offset bits, so a byte shift covers all sizes
  assign lane_c = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = lane_c;
    case (size_i)
      SZ_B: data_o = unsigned_i ? {24'b0, lane_c[7:0]}
                                : {{24{lane_c[7]}}, lane_c[7:0]};
      SZ_H: data_o = unsigned_i ? {16'b0, lane_c[15:0]}
                                : {{16{lane_c[15]}}, lane_c[15:0]};
      default: data_o = lane_c;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: issues byte/half/word loads and stores over a req/ack
// data-memory port, stalls the pipeline while busy, flags misaligned accesses
// and ack timeouts.
//   clk, reset            : clock, async active-low reset
//   ex_valid, MemRead,
//   MemWrite, Funct3,
//   ALUResult, StoreData  : access request from EX
//   lsu_busy              : combinational stall request
//   lsu_done, ReadData,
//   misaligned, bus_error : one-cycle completion with status/result
//   dmem_*                : data-memory request port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic                  lsu_busy,
  output logic                  lsu_done,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  misaligned,
  output logic                  bus_error,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ack
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  lsu_size_t             size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  mis_q, mis_d;
  logic                  berr_q, berr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  accept_c;
  lsu_size_t             acc_size_c;
  logic [DATA_WIDTH-1:0] ext_data_c;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^ALUResult[DATA_WIDTH-1:ADDR_WIDTH];

  assign accept_c   = (state_q == IDLE) && ex_valid && (MemRead || MemWrite);
  assign acc_size_c = f3_size(Funct3);

  load_extend u_load_extend (
    .rdata_i    (dmem_rdata),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data_c)
  );

  // State and access registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          addr_d = ALUResult[ADDR_WIDTH-1:0];
          size_d = acc_size_c;
          uns_d  = f3_unsigned(Funct3);
          we_d   = MemWrite;
          cnt_d  = '0;
          if (is_misaligned(acc_size_c, ALUResult[1:0])) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            be_d    = byte_enable(acc_size_c, ALUResult[1:0]);
            wdata_d = lane_wdata(acc_size_c, StoreData);
          end
        end
      end
      REQ: begin
        // Ack takes priority over a timeout in the same cycle
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          if (!we_q) rdata_d = ext_data_c;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          berr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lsu_busy   = accept_c || (state_q == REQ);
  assign lsu_done   = done_q;
  assign ReadData   = rdata_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, StoreData;
  logic        lsu_busy, lsu_done, misaligned, bus_error;
  logic [31:0] ReadData;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [8:0]  dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_rd = 32'h0;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .ALUResult  (ALUResult),
    .StoreData  (StoreData),
    .lsu_busy   (lsu_busy),
    .lsu_done   (lsu_done),
    .ReadData   (ReadData),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int n   = nbytes(f3);
    int off = int'(addr % 4);
    int m   = ((1 << n) - 1) << off;
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int n = nbytes(f3);
    int off = int'(addr % 4);
    logic [31:0] v = rd >> (8 * off);
    logic sgn = (f3 == 3'b000) || (f3 == 3'b001);
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One full access starting at a negedge in IDLE; ack_delay = REQ cycle carrying ack, 0 = never
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdw, input int ack_delay);
    int  n   = nbytes(f3);
    bit  mis = ((addr % 512) % n) != 0;
    int  exp_req = (ack_delay == 0) ? TIMEOUT : ack_delay;
    ex_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
    ALUResult = addr; StoreData = sd;
    #1;
    check("busy_accept", 32'(lsu_busy), 32'd1);
    @(negedge clk);
    ex_valid = 1'b0; MemRead = 1'($urandom); MemWrite = 1'($urandom);
    Funct3 = 3'($urandom); ALUResult = $urandom; StoreData = $urandom;
    #1;
    if (!mis) begin
      for (int k = 1; k <= exp_req; k++) begin
        check("req_held", 32'(dmem_req), 32'd1);
        check("busy_req", 32'(lsu_busy), 32'd1);
        if (k == 1 || k == exp_req) begin
          check("addr", 32'(dmem_addr), (addr % 512) / 4 * 4);
          check("we", 32'(dmem_we), 32'(wr));
          check("be", 32'(dmem_be), 32'(m_be(f3, addr)));
          if (wr) check("wdata", dmem_wdata, m_wdata(f3, sd));
        end
        if (k == exp_req && ack_delay != 0) begin
          dmem_ack = 1'b1; dmem_rdata = rdw;
        end else begin
          dmem_rdata = $urandom;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
      end
      if (!wr && ack_delay != 0) exp_rd = m_load(f3, addr, rdw);
    end
    check("done", 32'(lsu_done), 32'd1);
    check("misaligned", 32'(misaligned), 32'(mis));
    check("bus_error", 32'(bus_error), 32'(!mis && ack_delay == 0));
    check("req_after", 32'(dmem_req), 32'd0);
    check("busy_done", 32'(lsu_busy), 32'd0);
    check("readdata", ReadData, exp_rd);
    // Request presented during DONE must be ignored
    ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h0;
    #1;
    check("busy_in_done", 32'(lsu_busy), 32'd0);
    @(negedge clk);
    ex_valid = 1'b0; MemRead = 1'b0;
    #1;
    check("done_once", 32'(lsu_done), 32'd0);
    check("no_req_idle", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b0; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0;
    ALUResult = 32'h0; StoreData = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
    @(negedge clk); #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_busy", 32'(lsu_busy), 32'd0);
    check("rst_done", 32'(lsu_done), 32'd0);
    check("rst_readdata", ReadData, 32'h0);
    check("rst_flags", {30'b0, misaligned, bus_error}, 32'd0);
    check("rst_port", {dmem_wdata[22:0], dmem_addr} | 32'(dmem_be) | 32'(dmem_we), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // LW, ack on third request cycle
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 3);
    check("lw_const", ReadData, 32'hDEAD_BEEF);
    // LB / LBU from the top lane
    access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF_0000, 1);
    check("lb_const", ReadData, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF_0000, 2);
    check("lbu_const", ReadData, 32'h0000_0080);
    // SH upper half
    access(1'b0, 1'b1, 3'b001, 32'h06, 32'h1234_ABCD, 32'h0, 1);
    // Misaligned LW leaves ReadData alone
    access(1'b1, 1'b0, 3'b010, 32'h0A, 32'h0, 32'h1111_1111, 1);
    check("mis_keep", ReadData, 32'h0000_0080);
    // Timeout, then ack landing exactly on the timeout cycle
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 0);
    access(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 32'hCAFE_F00D, TIMEOUT);
    // Both MemRead and MemWrite: store wins
    access(1'b1, 1'b1, 3'b000, 32'h31, 32'h0000_005A, 32'h0, 2);

    // ex_valid without a memory op does nothing
    ex_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = 32'h40;
    #1;
    check("noop_busy", 32'(lsu_busy), 32'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    check("noop_req", 32'(dmem_req), 32'd0);
    check("noop_done", 32'(lsu_done), 32'd0);

    // Reset while in REQ
    ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h40;
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_req", 32'(dmem_req), 32'd0);
    check("async_rst_busy", 32'(lsu_busy), 32'd0);
    check("async_rst_rd", ReadData, 32'h0);
    exp_rd = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h0BAD_F00D, 2);

    // Randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      logic r, w;
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      access(r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
